// File: rtl/rx_packet_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_packet_assembler_if
//  Description : Byte-stream input and packet/error output bundle of the
//                receive packet assembler. The master side is the UART
//                receiver plus the packet consumer; the slave side is the
//                assembler itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_packet_assembler_if;

    // Byte stream from the UART receiver
    logic       byte_valid;
    logic [7:0] byte_data;

    // Packet hand-off to the controller
    logic       packet_ack;
    logic       packet_valid;
    logic [7:0] command;
    logic [7:0] address;

    // Discard reporting
    logic       error_valid;
    logic [1:0] error_code;
    logic [7:0] error_count;

    modport master (
        output byte_valid,
        output byte_data,
        output packet_ack,
        input  packet_valid,
        input  command,
        input  address,
        input  error_valid,
        input  error_code,
        input  error_count
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  packet_ack,
        output packet_valid,
        output command,
        output address,
        output error_valid,
        output error_code,
        output error_count
    );

endinterface
`default_nettype wire

// File: rtl/rx_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_packet_assembler
//  Description : Assembles two-byte packets (command, address) from a UART
//                byte stream. It validates both bytes, times out a missing
//                address byte, holds a good packet until it is acknowledged
//                and reports every discarded packet with a reason code and a
//                saturating counter. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_packet_assembler #(
    parameter int         TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0] MAX_COMMAND    = 8'h07,
    parameter int         NUM_ADDR       = 32
) (
    input  wire                          clock_50Mhz,
    input  wire                          reset_n,
    rx_packet_assembler_if.slave         bus
);

    // Counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
    localparam int              c_CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]      c_NUM_ADDR     = 9'(NUM_ADDR);

    localparam logic [1:0] c_ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] c_ERR_BAD_CMD = 2'd1;
    localparam logic [1:0] c_ERR_BAD_ADR = 2'd2;
    localparam logic [1:0] c_ERR_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_HOLD      = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [7:0]           r_pending_cmd;
    logic [c_CNT_W-1:0]   r_timeout_cnt;

    logic                 r_packet_valid;
    logic [7:0]           r_command;
    logic [7:0]           r_address;
    logic                 r_error_valid;
    logic [1:0]           r_error_code;
    logic [7:0]           r_error_count;

    logic                 w_latch_cmd;
    logic                 w_cnt_inc;
    logic                 w_load_packet;
    logic                 w_release_packet;
    logic                 w_error;
    logic [1:0]           w_error_code;
    logic                 w_bad_cmd;
    logic                 w_bad_addr;

    assign w_bad_cmd  = (r_pending_cmd > MAX_COMMAND);
    assign w_bad_addr = ({1'b0, bus.byte_data} >= c_NUM_ADDR);

    // State register
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_next     = r_state;
        w_latch_cmd      = 1'b0;
        w_cnt_inc        = 1'b0;
        w_load_packet    = 1'b0;
        w_release_packet = 1'b0;
        w_error          = 1'b0;
        w_error_code     = r_error_code;

        case (r_state)
            ST_IDLE: begin
                if (bus.byte_valid) begin
                    w_latch_cmd  = 1'b1;
                    w_state_next = ST_WAIT_ADDR;
                end
            end

            ST_WAIT_ADDR: begin
                // A byte arriving on the timeout cycle takes precedence.
                if (bus.byte_valid) begin
                    if (w_bad_cmd) begin
                        w_error      = 1'b1;
                        w_error_code = c_ERR_BAD_CMD;
                        w_state_next = ST_IDLE;
                    end else if (w_bad_addr) begin
                        w_error      = 1'b1;
                        w_error_code = c_ERR_BAD_ADR;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_load_packet = 1'b1;
                        w_state_next  = ST_HOLD;
                    end
                end else if (r_timeout_cnt == c_TIMEOUT_LAST) begin
                    w_error      = 1'b1;
                    w_error_code = c_ERR_TIMEOUT;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            ST_HOLD: begin
                if (bus.packet_ack) begin
                    // Acknowledge frees the slot, so a simultaneous byte is
                    // a legitimate new command rather than an overrun.
                    w_release_packet = 1'b1;
                    if (bus.byte_valid) begin
                        w_latch_cmd  = 1'b1;
                        w_state_next = ST_WAIT_ADDR;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (bus.byte_valid) begin
                    w_error      = 1'b1;
                    w_error_code = c_ERR_OVERRUN;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Pending command byte and address timeout counter
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_pending_cmd <= 8'h00;
            r_timeout_cnt <= '0;
        end else if (w_latch_cmd) begin
            r_pending_cmd <= bus.byte_data;
            r_timeout_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
        end
    end

    // Held packet registers
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_packet_valid <= 1'b0;
            r_command      <= 8'h00;
            r_address      <= 8'h00;
        end else if (w_load_packet) begin
            r_packet_valid <= 1'b1;
            r_command      <= r_pending_cmd;
            r_address      <= bus.byte_data;
        end else if (w_release_packet) begin
            r_packet_valid <= 1'b0;
        end
    end

    // Error pulse, sticky reason code and saturating discard counter
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_error_valid <= 1'b0;
            r_error_code  <= 2'd0;
            r_error_count <= 8'h00;
        end else begin
            r_error_valid <= w_error;
            r_error_code  <= w_error_code;
            if (w_error && (r_error_count != 8'hFF)) begin
                r_error_count <= r_error_count + 8'h01;
            end
        end
    end

    assign bus.packet_valid = r_packet_valid;
    assign bus.command      = r_command;
    assign bus.address      = r_address;
    assign bus.error_valid  = r_error_valid;
    assign bus.error_code   = r_error_code;
    assign bus.error_count  = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_rx_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_packet_assembler
//  Description : Self-checking bench for rx_packet_assembler: directed
//                scenarios followed by randomized byte/ack traffic, all
//                compared against a deadline-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_packet_assembler;

    localparam int         T    = 100;
    localparam logic [7:0] MAXC = 8'h07;
    localparam int         NA   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rx_packet_assembler_if bus();

    rx_packet_assembler #(
        .TIMEOUT_CYCLES (T),
        .MAX_COMMAND    (MAXC),
        .NUM_ADDR       (NA)
    ) dut (
        .clock_50Mhz (clk),
        .reset_n     (rst_n),
        .bus         (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: a packet is "waiting" until a deadline edge index,
    // "held" until acknowledged, otherwise idle.
    typedef enum int {M_IDLE, M_WAIT, M_HELD} mphase_t;
    mphase_t    ph;
    int         cyc;
    int         deadline;
    logic [7:0] m_pend;
    logic [7:0] m_cmd;
    logic [7:0] m_addr;
    logic       m_valid;
    logic       m_ev;
    logic [1:0] m_code;
    int         m_count;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("packet_valid", {7'b0, bus.packet_valid}, {7'b0, m_valid});
        chk("command",      bus.command,               m_cmd);
        chk("address",      bus.address,               m_addr);
        chk("error_valid",  {7'b0, bus.error_valid},  {7'b0, m_ev});
        chk("error_code",   {6'b0, bus.error_code},   {6'b0, m_code});
        chk("error_count",  bus.error_count,           8'(m_count));
    endtask

    task automatic model_reset();
        ph = M_IDLE; cyc = 0; deadline = 0; m_pend = 8'h00;
        m_cmd = 8'h00; m_addr = 8'h00; m_valid = 1'b0;
        m_ev = 1'b0; m_code = 2'd0; m_count = 0;
    endtask

    task automatic model_err(input logic [1:0] code);
        m_ev   = 1'b1;
        m_code = code;
        if (m_count < 255) m_count++;
    endtask

    task automatic model_edge(input logic bv, input logic [7:0] bd, input logic ack);
        cyc++;
        m_ev = 1'b0;
        case (ph)
            M_IDLE: if (bv) begin
                m_pend = bd; deadline = cyc + T; ph = M_WAIT;
            end
            M_WAIT: begin
                if (bv) begin
                    if (m_pend > MAXC) begin
                        model_err(2'd1); ph = M_IDLE;
                    end else if (int'(bd) >= NA) begin
                        model_err(2'd2); ph = M_IDLE;
                    end else begin
                        m_cmd = m_pend; m_addr = bd; m_valid = 1'b1; ph = M_HELD;
                    end
                end else if (cyc == deadline) begin
                    model_err(2'd0); ph = M_IDLE;
                end
            end
            M_HELD: begin
                if (ack) begin
                    m_valid = 1'b0;
                    if (bv) begin
                        m_pend = bd; deadline = cyc + T; ph = M_WAIT;
                    end else begin
                        ph = M_IDLE;
                    end
                end else if (bv) begin
                    model_err(2'd3);
                end
            end
            default: ph = M_IDLE;
        endcase
    endtask

    // One clock edge with the given inputs, checked one time unit later.
    task automatic step(input logic bv, input logic [7:0] bd, input logic ack);
        bus.byte_valid = bv;
        bus.byte_data  = bd;
        bus.packet_ack = ack;
        @(posedge clk);
        #1;
        model_edge(bv, bd, ack);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.packet_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.packet_ack = 1'b0;
        model_reset();
        do_reset();

        // Basic packet, bytes ten cycles apart, then acknowledge
        step(1'b1, 8'h03, 1'b0);
        idle(9);
        step(1'b1, 8'h05, 1'b0);
        chk("pkt_valid_034", {7'b0, bus.packet_valid}, 8'h01);
        chk("pkt_cmd_034",   bus.command, 8'h03);
        chk("pkt_addr_034",  bus.address, 8'h05);
        idle(3);
        step(1'b0, 8'h00, 1'b1);
        chk("pkt_release_034", {7'b0, bus.packet_valid}, 8'h00);

        // Address timeout exactly T cycles after the command strobe
        step(1'b1, 8'h01, 1'b0);
        idle(T - 1);
        chk("no_early_timeout", {7'b0, bus.error_valid}, 8'h00);
        step(1'b0, 8'h00, 1'b0);
        chk("timeout_pulse", {7'b0, bus.error_valid}, 8'h01);
        chk("timeout_code",  {6'b0, bus.error_code},  8'h00);
        chk("timeout_count", bus.error_count, 8'h01);
        step(1'b0, 8'h00, 1'b0);
        chk("timeout_one_cycle", {7'b0, bus.error_valid}, 8'h00);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("after_timeout_pkt", {7'b0, bus.packet_valid}, 8'h01);
        step(1'b0, 8'h00, 1'b1);

        // Validation errors, command check first
        step(1'b1, 8'h09, 1'b0); step(1'b1, 8'h05, 1'b0);
        chk("bad_cmd_code", {6'b0, bus.error_code}, 8'h01);
        step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h20, 1'b0);
        chk("bad_addr_code", {6'b0, bus.error_code}, 8'h02);
        step(1'b1, 8'h09, 1'b0); step(1'b1, 8'h20, 1'b0);
        chk("both_bad_code", {6'b0, bus.error_code}, 8'h01);
        idle(2);

        // Overrun while holding, then byte together with acknowledge
        step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        chk("overrun_code", {6'b0, bus.error_code}, 8'h03);
        chk("overrun_cmd",  bus.command, 8'h01);
        chk("overrun_addr", bus.address, 8'h02);
        step(1'b1, 8'h04, 1'b1);
        chk("ack_byte_no_err", {7'b0, bus.error_valid}, 8'h00);
        step(1'b1, 8'h02, 1'b0);
        chk("ack_byte_new_cmd", bus.command, 8'h04);
        step(1'b0, 8'h00, 1'b1);

        // Address byte on the timeout cycle wins
        step(1'b1, 8'h03, 1'b0);
        idle(T - 1);
        step(1'b1, 8'h07, 1'b0);
        chk("late_addr_valid", {7'b0, bus.packet_valid}, 8'h01);
        chk("late_addr_noerr", {7'b0, bus.error_valid}, 8'h00);
        chk("late_addr_addr",  bus.address, 8'h07);

        // Ack outside HOLD is ignored
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h05, 1'b1);
        step(1'b1, 8'h06, 1'b0);
        chk("ack_ignored_cmd", bus.command, 8'h05);

        // Asynchronous reset while holding
        do_reset();
        chk("reset_valid", {7'b0, bus.packet_valid}, 8'h00);
        chk("reset_count", bus.error_count, 8'h00);
        step(1'b1, 8'h02, 1'b0); step(1'b1, 8'h03, 1'b0);
        chk("first_byte_cmd", bus.command, 8'h02);
        step(1'b0, 8'h00, 1'b1);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'h09, 1'b0);
            step(1'b1, 8'h00, 1'b0);
        end
        chk("count_saturated", bus.error_count, 8'hFF);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int   r;
            logic bv;
            logic ack;
            logic [7:0] bd;
            r   = int'($urandom_range(0, 99));
            bv  = (r % 3 == 0);
            ack = ($urandom_range(0, 3) == 0);
            bd  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9))
                                              : 8'($urandom_range(0, 40));
            if (r < 3) begin
                idle(T + 5);
            end else begin
                step(bv, bd, ack);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
